dl_mem_arbiter: RTL
===================

DL_MEM_ARBITER -- requirements
Module: dl_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 25, meaning address width in 16-bit-word-aligned byte addresses.
REQ-002 SHALL have parameter DEPTH, default 4, meaning download write FIFO entries (power of two, at least 2).
REQ-003 SHALL have ports: clk  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: downloading  in  1  download active; dl_wr  in  1  one-cycle word write strobe; dl_addr  in  AW  word address; dl_data  in  16  word data.
REQ-005 SHALL have ports: cpu_req  in  1  CPU access request, held until ack; cpu_we  in  1  write; cpu_addr  in  AW; cpu_wdata  in  16; cpu_ack  out  1  one-cycle completion; cpu_rdata  out  16  read data.
REQ-006 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  AW; mem_wdata  out  16; mem_ack  in  1  one-cycle completion; mem_rdata  in  16.
REQ-007 SHALL have ports: dl_done  out  1  one-cycle pulse; dl_overflow  out  1  sticky lost-write flag.

Function
REQ-008 SHALL push {dl_addr, dl_data} into the FIFO on each clk edge where dl_wr=1 and the FIFO is not full.
REQ-009 SHALL set dl_overflow on dl_wr with a full FIFO, drop that word, and clear the flag only on reset or on a rising edge of downloading.
REQ-010 SHALL implement states IDLE, DL_ACC and CPU_ACC; mem_req=1 exactly when state is not IDLE.
REQ-011 SHALL in IDLE, with FIFO non-empty only, enter DL_ACC on the next edge.
REQ-012 SHALL in IDLE, with cpu_req=1 and FIFO empty, enter CPU_ACC on the next edge.
REQ-013 SHALL in IDLE with both pending alternate round-robin: DL_ACC if the last grant was CPU, else CPU_ACC.
REQ-014 SHALL hold mem_addr, mem_wdata and mem_we stable during DL_ACC and CPU_ACC, sourced from the FIFO head (mem_we=1) or the CPU inputs latched at grant.
REQ-015 SHALL on mem_ack in DL_ACC pop the FIFO head, record last grant as DL, and return to IDLE on the same edge.
REQ-016 SHALL on mem_ack in CPU_ACC register cpu_rdata from mem_rdata, pulse cpu_ack for exactly one cycle, record last grant as CPU, and return to IDLE.
REQ-017 SHALL ignore mem_ack while IDLE.
REQ-018 SHALL accept simultaneous push and pop in one cycle; occupancy stays unchanged and the pointers wrap modulo DEPTH.
REQ-019 SHALL give dl_wr-to-mem_req latency of 2 edges from an empty FIFO, IDLE and no CPU contention.
REQ-020 SHALL pulse dl_done for one cycle on the first edge where downloading=0 after a 1-to-0 transition, the FIFO is empty and the state is not DL_ACC.
REQ-021 SHALL still drain the FIFO after downloading falls, delaying dl_done until the drain completes.
REQ-022 SHALL keep cpu_req deasserting mid-access from aborting CPU_ACC; the access completes and cpu_ack still pulses.

Reset
REQ-023 SHALL on reset asynchronously force state IDLE, empty FIFO, last grant CPU, and mem_req, mem_we, cpu_ack, dl_done and dl_overflow to 0, with mem_addr, mem_wdata and cpu_rdata at 0.
REQ-024 SHALL on reset mid-access drop any in-flight DL or CPU access with no ack generated; on release, arbitration restarts from IDLE.

Verification
REQ-025 SHALL cover: single dl_wr addr 0xA0000 data 0x1234 with mem_ack 3 cycles after mem_req -> mem_req high from edge 2 with mem_we=1, addr 0xA0000 and data 0x1234; FIFO empty after ack.
REQ-026 SHALL cover: cpu_req read at 0x100 with mem_rdata 0xBEEF -> cpu_ack one cycle, cpu_rdata=0xBEEF, mem_we=0.
REQ-027 SHALL cover: continuous cpu_req with dl_wr every 2 cycles -> grants alternate DL, CPU, DL, CPU and no overflow at DEPTH=4.
REQ-028 SHALL cover: 5 dl_wr back-to-back with mem_ack withheld -> 4 stored, dl_overflow=1, first 4 words written in order once acks resume.
REQ-029 SHALL cover: downloading falls with 3 entries queued -> dl_done one cycle after the third mem_ack completes, not before.
REQ-030 SHALL cover: reset asserted during DL_ACC -> mem_req 0 immediately and FIFO empty; new dl_wr after release served normally.

Source files
------------

// File: rtl/dl_mem_arbiter.sv
// dl_mem_arbiter: shares one 16-bit memory port between a download write stream and a CPU.
//
// Download words are buffered in a small FIFO and written one at a time; CPU accesses are
// single outstanding requests held until acknowledged. When both are pending the grant
// alternates round-robin. A download completion pulse is raised once the download has ended
// and its buffered words have all been written.
//
// Ports:
//   clk, reset                       system clock, asynchronous active-high reset
//   downloading                      download active level
//   dl_wr, dl_addr, dl_data          one-cycle download word write
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata, cpu_ack, cpu_rdata    CPU access (req held until the one-cycle ack)
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_ack, mem_rdata    memory port (req held until the one-cycle ack)
//   dl_done                          one-cycle pulse when a finished download has drained
//   dl_overflow                      sticky: a download word was dropped on a full FIFO
module dl_mem_arbiter #(
    parameter int unsigned AW    = 25,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          downloading,
    input  logic          dl_wr,
    input  logic [AW-1:0] dl_addr,
    input  logic [15:0]   dl_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [15:0]   cpu_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [15:0]   mem_rdata,
    output logic          dl_done,
    output logic          dl_overflow
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StDlAcc,
        StCpuAcc
    } state_e;

    state_e state_q, state_d;

    // FIFO storage is not reset; only the pointers and occupancy are.
    logic [AW-1:0] fifo_addr_q [DEPTH];
    logic [15:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q, count_d;

    logic          last_cpu_q;   // 1: most recent grant went to the CPU
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [15:0]   mem_wdata_q;
    logic          cpu_ack_q;
    logic [15:0]   cpu_rdata_q;
    logic          downloading_q;
    logic          done_pend_q;  // download has ended, waiting for the FIFO to drain
    logic          dl_done_q;
    logic          overflow_q;

    logic fifo_empty, fifo_full;
    logic push, pop;
    logic grant_dl, grant_cpu, cpu_done;
    logic dl_rise, dl_fall, done_fire;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCnt);
    assign push       = dl_wr && !fifo_full;

    assign dl_rise   = downloading && !downloading_q;
    assign dl_fall   = !downloading && downloading_q;
    assign done_fire = (dl_fall || done_pend_q) && !downloading && fifo_empty &&
                       (state_q != StDlAcc);

    // Arbitration and access sequencing.
    always_comb begin
        state_d   = state_q;
        grant_dl  = 1'b0;
        grant_cpu = 1'b0;
        pop       = 1'b0;
        cpu_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Download wins when it is alone or when the CPU had the last turn.
                if (!fifo_empty && (!cpu_req || last_cpu_q)) begin
                    grant_dl = 1'b1;
                    state_d  = StDlAcc;
                end else if (cpu_req) begin
                    grant_cpu = 1'b1;
                    state_d   = StCpuAcc;
                end
            end
            StDlAcc: begin
                if (mem_ack) begin
                    pop     = 1'b1;
                    state_d = StIdle;
                end
            end
            StCpuAcc: begin
                if (mem_ack) begin
                    cpu_done = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= dl_addr;
            fifo_data_q[wptr_q] <= dl_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            last_cpu_q    <= 1'b1;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            downloading_q <= 1'b0;
            done_pend_q   <= 1'b0;
            dl_done_q     <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;

            // Access attributes are captured at grant and held for the whole access.
            if (grant_dl) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= fifo_addr_q[rptr_q];
                mem_wdata_q <= fifo_data_q[rptr_q];
            end else if (grant_cpu) begin
                mem_we_q    <= cpu_we;
                mem_addr_q  <= cpu_addr;
                mem_wdata_q <= cpu_wdata;
            end else if (pop || cpu_done) begin
                mem_we_q <= 1'b0;
            end

            if (pop)      last_cpu_q <= 1'b0;
            if (cpu_done) last_cpu_q <= 1'b1;

            cpu_ack_q <= cpu_done;
            if (cpu_done) cpu_rdata_q <= mem_rdata;

            downloading_q <= downloading;
            dl_done_q     <= done_fire;
            if (dl_rise || done_fire) begin
                done_pend_q <= 1'b0;
            end else if (dl_fall) begin
                done_pend_q <= 1'b1;
            end

            // A lost word outranks a simultaneous restart of the download.
            if (dl_wr && fifo_full) begin
                overflow_q <= 1'b1;
            end else if (dl_rise) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign mem_req     = (state_q != StIdle);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign dl_done     = dl_done_q;
    assign dl_overflow = overflow_q;

endmodule
